// File: rtl/uart_rx_pkt_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkt_assembler
// Description : Groups received UART bytes into {byte0, byte1} packets with a
//               baud-scaled inter-byte timeout; holds each packet until acked.
//               Optional XOR checksum byte enabled by macro PKT_XOR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_assembler #(
    parameter int BAUD_CNT_MAX_9600  = 5208,
    parameter int BAUD_CNT_MAX_19200 = 2604,
    parameter int BAUD_CNT_MAX_38400 = 1302,
    parameter int TIMEOUT_BYTES      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_setting,
    input  logic       rx_end_flag,
    input  logic [7:0] rx_data,
    input  logic       pkt_ack,
    output logic       pkt_valid,
    output logic [7:0] pkt_byte0,
    output logic [7:0] pkt_byte1,
    output logic       timeout_err,
    output logic       overrun_err,
    output logic       chk_err
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait_b1 = 2'd1;
    localparam logic [1:0] c_st_wait_ck = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    localparam logic [23:0] c_limit_9600  = 24'(TIMEOUT_BYTES * 10 * BAUD_CNT_MAX_9600);
    localparam logic [23:0] c_limit_19200 = 24'(TIMEOUT_BYTES * 10 * BAUD_CNT_MAX_19200);
    localparam logic [23:0] c_limit_38400 = 24'(TIMEOUT_BYTES * 10 * BAUD_CNT_MAX_38400);
    localparam logic [23:0] c_timer_max   = 24'hFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [23:0] r_timer;
    logic [23:0] w_limit;
    logic        w_timer_expired;
    logic        w_waiting;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic        r_timeout_err;
    logic        r_overrun_err;
    logic        w_load_b0;
    logic        w_load_b1;
    logic        w_timer_clr;
    logic        w_timeout;
    logic        w_overrun;
    logic        w_chk_fail;

    // Limit follows baud_setting combinationally so a mid-packet change takes
    // effect at once; >= makes a shrinking limit still expire promptly.
    always_comb begin
        case (baud_setting)
            2'd0:    w_limit = c_limit_9600;
            2'd1:    w_limit = c_limit_19200;
            default: w_limit = c_limit_38400;
        endcase
    end

    assign w_timer_expired = (r_timer >= (w_limit - 24'd1));
    assign w_waiting       = (r_state == c_st_wait_b1) || (r_state == c_st_wait_ck);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (rx_end_flag) w_state_next = c_st_wait_b1;
            end
            c_st_wait_b1: begin
                if (rx_end_flag) begin
`ifdef PKT_XOR_CHECK_EN
                    w_state_next = c_st_wait_ck;
`else
                    w_state_next = c_st_hold;
`endif
                end else if (w_timer_expired) begin
                    w_state_next = c_st_idle;
                end
            end
`ifdef PKT_XOR_CHECK_EN
            c_st_wait_ck: begin
                if (rx_end_flag) begin
                    w_state_next = (rx_data == (r_byte0 ^ r_byte1)) ? c_st_hold : c_st_idle;
                end else if (w_timer_expired) begin
                    w_state_next = c_st_idle;
                end
            end
`endif
            c_st_hold: begin
                if (pkt_ack) w_state_next = rx_end_flag ? c_st_wait_b1 : c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        pkt_valid   = (r_state == c_st_hold);
        w_load_b0   = 1'b0;
        w_load_b1   = 1'b0;
        w_timer_clr = 1'b0;
        w_timeout   = 1'b0;
        w_overrun   = 1'b0;
        w_chk_fail  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_load_b0   = rx_end_flag;
                w_timer_clr = rx_end_flag;
            end
            c_st_wait_b1: begin
                w_load_b1   = rx_end_flag;
                w_timer_clr = rx_end_flag;
                w_timeout   = !rx_end_flag && w_timer_expired;
            end
            c_st_wait_ck: begin
                w_timeout   = !rx_end_flag && w_timer_expired;
                w_chk_fail  = rx_end_flag && (rx_data != (r_byte0 ^ r_byte1));
            end
            c_st_hold: begin
                w_load_b0   = rx_end_flag && pkt_ack;
                w_timer_clr = rx_end_flag && pkt_ack;
                w_overrun   = rx_end_flag && !pkt_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte0       <= 8'h00;
            r_byte1       <= 8'h00;
            r_timer       <= 24'd0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_load_b0) r_byte0 <= rx_data;
            if (w_load_b1) r_byte1 <= rx_data;
            if (w_timer_clr) begin
                r_timer <= 24'd0;
            end else if (w_waiting && (r_timer != c_timer_max)) begin
                r_timer <= r_timer + 24'd1;
            end
            r_timeout_err <= w_timeout;
            r_overrun_err <= w_overrun;
        end
    end

`ifdef PKT_XOR_CHECK_EN
    logic r_chk_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err <= 1'b0;
        end else begin
            r_chk_err <= w_chk_fail;
        end
    end
    assign chk_err = r_chk_err;
`else
    logic w_chk_unused;
    assign w_chk_unused = w_chk_fail;
    assign chk_err      = 1'b0;
`endif

    assign pkt_byte0   = r_byte0;
    assign pkt_byte1   = r_byte1;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_pkt_assembler
// Description : Directed, scoreboard-based bench for uart_rx_pkt_assembler
//               (default 2-byte build) using scaled-down baud counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_assembler;

    localparam int c_b96  = 40;
    localparam int c_b192 = 20;
    localparam int c_b384 = 10;
    localparam int c_tob  = 4;
    localparam int c_l96  = c_tob * 10 * c_b96;
    localparam int c_l192 = c_tob * 10 * c_b192;
    localparam int c_l384 = c_tob * 10 * c_b384;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_setting;
    logic       rx_end_flag;
    logic [7:0] rx_data;
    logic       pkt_ack;
    logic       pkt_valid;
    logic [7:0] pkt_byte0;
    logic [7:0] pkt_byte1;
    logic       timeout_err;
    logic       overrun_err;
    logic       chk_err;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
    } pkt_t;

    pkt_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    uart_rx_pkt_assembler #(
        .BAUD_CNT_MAX_9600  (c_b96),
        .BAUD_CNT_MAX_19200 (c_b192),
        .BAUD_CNT_MAX_38400 (c_b384),
        .TIMEOUT_BYTES      (c_tob)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_setting (baud_setting),
        .rx_end_flag  (rx_end_flag),
        .rx_data      (rx_data),
        .pkt_ack      (pkt_ack),
        .pkt_valid    (pkt_valid),
        .pkt_byte0    (pkt_byte0),
        .pkt_byte1    (pkt_byte1),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err),
        .chk_err      (chk_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rx_end_flag strobe; returns just after the edge that sampled it.
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_end_flag = 1'b1;
        rx_data     = b;
        @(posedge clk);
        #1;
        rx_end_flag = 1'b0;
    endtask

    task automatic push(input logic [7:0] b0, input logic [7:0] b1);
        pkt_t p;
        p.b0 = b0;
        p.b1 = b1;
        sb.push_back(p);
    endtask

    task automatic check_pkt(input string tag);
        pkt_t p;
        int   n = 0;
        while (!pkt_valid && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            p = sb.pop_front();
            chk({tag, "_b0"}, 32'(pkt_byte0), 32'(p.b0));
            chk({tag, "_b1"}, 32'(pkt_byte1), 32'(p.b1));
            repeat (3) tick();
            chk({tag, "_hold_valid"}, 32'(pkt_valid), 32'd1);
            chk({tag, "_hold_b0"}, 32'(pkt_byte0), 32'(p.b0));
            chk({tag, "_hold_b1"}, 32'(pkt_byte1), 32'(p.b1));
        end
    endtask

    task automatic ack_pkt(input string tag);
        @(posedge clk);
        #1;
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
        chk({tag, "_ack_clears"}, 32'(pkt_valid), 32'd0);
    endtask

    task automatic measure_timeout(input string tag, input logic [1:0] baud, input int exp);
        int n = 0;
        baud_setting = baud;
        send(8'hE0);
        while (!timeout_err && n < 2 * exp) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'(exp));
        chk({tag, "_no_valid"}, 32'(pkt_valid), 32'd0);
        tick();
        chk({tag, "_pulse_1cyc"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        baud_setting = 2'd2;
        rx_end_flag  = 1'b0;
        rx_data      = 8'h00;
        pkt_ack      = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(pkt_valid), 32'd0);
        chk("rst_b0", 32'(pkt_byte0), 32'h00);
        chk("rst_b1", 32'(pkt_byte1), 32'h00);
        chk("rst_errs", 32'({timeout_err, overrun_err, chk_err}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic packet with a 200 ns gap, valid one cycle after the last byte
        push(8'h3C, 8'h30);
        send(8'h3C);
        chk("t1_partial_not_valid", 32'(pkt_valid), 32'd0);
        repeat (10) tick();
        send(8'h30);
        chk("t1_latency", 32'(pkt_valid), 32'd1);
        check_pkt("t1");
        ack_pkt("t1");

        // pkt_ack outside HOLD has no effect
        push(8'h55, 8'h66);
        send(8'h55);
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        send(8'h66);
        check_pkt("ack_ignored");
        ack_pkt("ack_ignored");

        // Timeout: partial byte dropped, next byte becomes byte0
        measure_timeout("to_baud2", 2'd2, c_l384);
        send(8'h18);
        chk("to_new_b0", 32'(pkt_byte0), 32'h18);
        chk("to_new_not_valid", 32'(pkt_valid), 32'd0);
        push(8'h18, 8'h77);
        send(8'h77);
        check_pkt("to_next");
        ack_pkt("to_next");
        measure_timeout("to_baud0", 2'd0, c_l96);
        measure_timeout("to_baud1", 2'd1, c_l192);
        measure_timeout("to_baud3", 2'd3, c_l384);
        baud_setting = 2'd2;

        // Byte arriving in the last timer cycle wins over the timeout
        push(8'hA1, 8'hA2);
        send(8'hA1);
        repeat (c_l384 - 2) @(posedge clk);
        send(8'hA2);
        chk("edge_no_timeout", 32'(timeout_err), 32'd0);
        check_pkt("edge");
        ack_pkt("edge");

        // Overrun while holding
        push(8'h04, 8'h02);
        send(8'h04);
        send(8'h02);
        send(8'h12);
        chk("ovr_pulse", 32'(overrun_err), 32'd1);
        tick();
        chk("ovr_pulse_1cyc", 32'(overrun_err), 32'd0);
        check_pkt("ovr");
        ack_pkt("ovr");

        // Ack coincident with a new byte: byte becomes next byte0
        push(8'h11, 8'h22);
        send(8'h11);
        send(8'h22);
        check_pkt("co_first");
        @(posedge clk);
        #1;
        pkt_ack     = 1'b1;
        rx_end_flag = 1'b1;
        rx_data     = 8'hC8;
        @(posedge clk);
        #1;
        pkt_ack     = 1'b0;
        rx_end_flag = 1'b0;
        chk("co_no_overrun", 32'(overrun_err), 32'd0);
        chk("co_valid_drop", 32'(pkt_valid), 32'd0);
        push(8'hC8, 8'h32);
        send(8'h32);
        check_pkt("co_second");
        ack_pkt("co_second");

        // Reset mid-packet discards the partial byte
        send(8'h12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
        chk("mid_rst_b0", 32'(pkt_byte0), 32'h00);
        chk("mid_rst_errs", 32'({timeout_err, overrun_err, chk_err}), 32'd0);
        push(8'h12, 8'h0B);
        send(8'h12);
        send(8'h0B);
        check_pkt("post_rst");
        ack_pkt("post_rst");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("chk_err_tied", 32'(chk_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
